// File: rtl/aes_gcm_pkg.sv
// Shared definitions for the AES-GCM decrypt block: FSM encoding, J0 counter seed, block limit.
// Latency: none (package only).
// Backpressure: none (package only).
package aes_gcm_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CALC_H,
        CALC_EJ0,
        AAD_MUL,
        CT_WAIT,
        CT_OUT,
        CT_MUL,
        LEN_MUL,
        FINAL
    } state_t;

    // Counter value of J0 = iv || 32'h1; data blocks start one above it
    localparam logic [31:0] J0_CTR_INIT = 32'h1;

    // Last block is forced once the message reaches this many blocks
    localparam logic [31:0] GCM_MAX_BLOCKS = 32'hFFFF_FFFE;

    // GHASH reduction constant in GCM reflected bit order
    localparam logic [127:0] GCM_R = {8'hE1, 120'd0};

endpackage

// File: rtl/aes_encrypt.sv
// Purely combinational AES-128 block encryption (full key schedule unrolled).
// Latency: 0 cycles, result settles in the same cycle as key/pt.
// Backpressure: none; output simply follows inputs.
module aes_encrypt (
    input  logic [127:0] key,
    input  logic [127:0] pt,
    output logic [127:0] ct
);

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gmul8(sq, sq);
            r  = gmul8(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] k, input logic [127:0] b);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [4];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [7:0]  a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = b[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            tmp  = {w[3][23:0], w[3][31:24]};
            tmp  = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {rc, 24'h0};
            w[0] = w[0] ^ tmp;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            rc   = xt(rc);
            // SubBytes and ShiftRows together: byte (row r, col c) comes from col c+r
            for (int i = 0; i < 16; i++) t[i] = sbox(s[4*(((i/4) + (i%4)) % 4) + (i%4)]);
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    assign ct = aes128(key, pt);

endmodule

// File: rtl/gf128_mult_serial.sv
// Bit-serial GF(2^128) multiplier in GCM bit order (a bit 127 = coefficient x^0).
// Latency: result valid (done=1) in the 128th cycle after the start edge.
// Backpressure: none; a new start reloads operands and restarts immediately.
module gf128_mult_serial
    import aes_gcm_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] a,
    input  logic [127:0] b,
    output logic         done,
    output logic [127:0] result
);

    logic [127:0] x_r, v_r, z_r;
    logic [6:0]   cnt_r;
    logic         run_r;
    logic [127:0] z_step, v_step;

    // One multiply-accumulate step; the final step is exposed combinationally
    always_comb begin
        z_step = x_r[127] ? (z_r ^ v_r) : z_r;
        v_step = v_r[0] ? ((v_r >> 1) ^ GCM_R) : (v_r >> 1);
        done   = run_r && (cnt_r == 7'd127);
        result = z_step;
    end

    // Operand load on start, then one bit of a per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r   <= '0;
            v_r   <= '0;
            z_r   <= '0;
            cnt_r <= '0;
            run_r <= 1'b0;
        end else if (start) begin
            x_r   <= a;
            v_r   <= b;
            z_r   <= '0;
            cnt_r <= '0;
            run_r <= 1'b1;
        end else if (run_r) begin
            x_r   <= {x_r[126:0], 1'b0};
            v_r   <= v_step;
            z_r   <= z_step;
            cnt_r <= cnt_r + 7'd1;
            if (cnt_r == 7'd127) run_r <= 1'b0;
        end
    end

endmodule

// File: rtl/aes_gcm_decrypt.sv
// AES-128-GCM decrypt with one AAD block; plaintext released before tag check. Optional AES_GCM_TAG_OUT_EN adds calc_tag.
// Latency: 3 + 128*aad_valid + sum(130 + stalls) per ciphertext block + 128 cycles from start to done.
// Backpressure: one block in flight; in_ready only while waiting, plaintext held until out_ready.
module aes_gcm_decrypt
    import aes_gcm_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key,
    input  logic [95:0]  iv,
    input  logic [127:0] aad,
    input  logic         aad_valid,
    input  logic         ct_present,
    input  logic [127:0] tag_in,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic         done,
    output logic         tag_ok
`ifdef AES_GCM_TAG_OUT_EN
    ,
    output logic [127:0] calc_tag
`endif
);

    state_t       state_r, state_nx;
    logic [127:0] key_r, aad_r, tag_r, h_r, ej0_r, s_r, ct_r, pt_r;
    logic [95:0]  iv_r;
    logic         aad_v_r, ct_p_r, last_r;
    logic [31:0]  ctr_r, blk_r, len_blk;
    logic [127:0] aes_in, aes_out, len_vec, s_cur;
    logic         mul_start, mul_done;
    logic [127:0] mul_a, mul_res;

    aes_encrypt u_aes (
        .key (key_r),
        .pt  (aes_in),
        .ct  (aes_out)
    );

    gf128_mult_serial u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .a      (mul_a),
        .b      (h_r),
        .done   (mul_done),
        .result (mul_res)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nx;
    end

    // Next state, AES input select and multiplier launch
    always_comb begin
        state_nx  = state_r;
        aes_in    = '0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_start = 1'b0;
        mul_a     = '0;
        // GHASH value as it will be once the running multiply retires this cycle
        s_cur     = mul_done ? mul_res : s_r;
        len_blk   = (state_r == CT_MUL) ? (blk_r + 32'd1) : blk_r;
        len_vec   = {(aad_v_r ? 64'd128 : 64'd0), 25'd0, len_blk, 7'd0};
        case (state_r)
            IDLE: if (start) state_nx = CALC_H;
            CALC_H: state_nx = CALC_EJ0;
            CALC_EJ0: begin
                aes_in = {iv_r, J0_CTR_INIT};
                if (aad_v_r) begin
                    state_nx  = AAD_MUL;
                    mul_start = 1'b1;
                    mul_a     = aad_r;
                end else if (ct_p_r) begin
                    state_nx  = CT_WAIT;
                end else begin
                    state_nx  = LEN_MUL;
                    mul_start = 1'b1;
                    mul_a     = s_cur ^ len_vec;
                end
            end
            AAD_MUL: if (mul_done) begin
                if (ct_p_r) begin
                    state_nx  = CT_WAIT;
                end else begin
                    state_nx  = LEN_MUL;
                    mul_start = 1'b1;
                    mul_a     = s_cur ^ len_vec;
                end
            end
            CT_WAIT: begin
                in_ready = 1'b1;
                aes_in   = {iv_r, ctr_r};
                if (in_valid) state_nx = CT_OUT;
            end
            CT_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx  = CT_MUL;
                    mul_start = 1'b1;
                    mul_a     = s_r ^ ct_r;
                end
            end
            CT_MUL: if (mul_done) begin
                if (last_r) begin
                    state_nx  = LEN_MUL;
                    mul_start = 1'b1;
                    mul_a     = s_cur ^ len_vec;
                end else begin
                    state_nx  = CT_WAIT;
                end
            end
            LEN_MUL: if (mul_done) state_nx = FINAL;
            FINAL: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Message context capture, keystream application and GHASH accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            key_r   <= '0;
            iv_r    <= '0;
            aad_r   <= '0;
            aad_v_r <= 1'b0;
            ct_p_r  <= 1'b0;
            tag_r   <= '0;
            h_r     <= '0;
            ej0_r   <= '0;
            s_r     <= '0;
            ct_r    <= '0;
            pt_r    <= '0;
            ctr_r   <= '0;
            blk_r   <= '0;
            last_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: if (start) begin
                    key_r   <= key;
                    iv_r    <= iv;
                    aad_r   <= aad;
                    aad_v_r <= aad_valid;
                    ct_p_r  <= ct_present;
                    tag_r   <= tag_in;
                    s_r     <= '0;
                    ctr_r   <= '0;
                    blk_r   <= '0;
                    last_r  <= 1'b0;
                end
                CALC_H: h_r <= aes_out;
                CALC_EJ0: begin
                    ej0_r <= aes_out;
                    ctr_r <= J0_CTR_INIT + 32'd1;
                end
                CT_WAIT: if (in_valid) begin
                    ct_r   <= in_data;
                    pt_r   <= in_data ^ aes_out;
                    last_r <= in_last || ((blk_r + 32'd1) == GCM_MAX_BLOCKS);
                end
                CT_OUT: if (out_ready) pt_r <= '0;
                default: ;
            endcase
            if (mul_done) begin
                s_r <= mul_res;
                if (state_r == CT_MUL) begin
                    ctr_r <= ctr_r + 32'd1;
                    blk_r <= blk_r + 32'd1;
                end
            end
        end
    end

    // Status and result outputs, forced to zero outside their valid windows
    always_comb begin
        busy     = (state_r != IDLE);
        done     = (state_r == FINAL);
        tag_ok   = done && ((s_r ^ ej0_r) == tag_r);
        out_data = out_valid ? pt_r : '0;
`ifdef AES_GCM_TAG_OUT_EN
        calc_tag = done ? (s_r ^ ej0_r) : '0;
`endif
    end

endmodule
